// File: rtl/num_str_arbiter_pkg.sv
// Shared types and constants for the number-string arbiter and its siblings.
package num_str_arbiter_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} arb_state_e;

  localparam logic [7:0] CHAR_ZERO  = 8'h30;
  localparam logic [7:0] CHAR_SPACE = 8'h20;

  typedef logic [39:0] digit_str_t;

  // Converter output for a value of zero, also the reset image of out_str.
  localparam digit_str_t STR_ZEROS = {5{CHAR_ZERO}};

endpackage

// File: rtl/num_str_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after rr_ptr,
// wrapping modulo NREQ. Shared with the tone/key arbiters.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 3
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  rr_ptr,
  output logic [IDW-1:0]  gnt_id,
  output logic            any_req
);

  int   idx;
  logic found;

  // Walk the requesters starting at the pointer; the first hit wins.
  always_comb begin
    gnt_id  = '0;
    any_req = |req;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        gnt_id = IDW'(idx);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/num_str_arbiter.sv
// Shares one binary-to-ASCII converter among NREQ display clients.
// Grants round-robin, feeds the converter from a register, waits CONV_LAT
// cycles, captures the string, blanks leading zeros and returns it tagged.
module num_str_arbiter
  import num_str_arbiter_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int IDW      = 3,
  parameter int CONV_LAT = 1,
  parameter int MAX_VAL  = 9999,
  parameter int BLANK_LZ = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*14-1:0] value,
  output logic [NREQ-1:0]   ack,
  output logic [13:0]       conv_bin,
  input  logic [39:0]       conv_str,
  output logic [39:0]       out_str,
  output logic [IDW-1:0]    out_id,
  output logic              out_valid,
  output logic              ovf,
  output logic              busy
);

  // Parameter sanity, rejected at elaboration.
  if (MAX_VAL > 16383 || MAX_VAL < 0) begin : g_bad_max
    $error("num_str_arbiter: MAX_VAL must fit in 14 bits");
  end
  if (CONV_LAT < 1 || CONV_LAT > 7) begin : g_bad_lat
    $error("num_str_arbiter: CONV_LAT must be 1..7");
  end
  if (NREQ < 2 || NREQ > 8 || (2 ** IDW) < NREQ) begin : g_bad_nreq
    $error("num_str_arbiter: NREQ must be 2..8 and fit in IDW bits");
  end

  localparam logic [13:0] MAX14  = 14'(MAX_VAL);
  localparam logic [2:0]  LAT_M1 = 3'(CONV_LAT - 1);

  arb_state_e  state;
  logic [2:0]  cnt;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] gnt_id;
  logic        clamp;
  digit_str_t  cap_str;

  logic [IDW-1:0] pick_id;
  logic        any_req;
  logic [13:0] sel_val;
  logic        sel_over;
  digit_str_t  blanked;
  logic        lead;

  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .gnt_id (pick_id),
    .any_req(any_req)
  );

  // Value of the candidate requester and whether it needs clamping.
  always_comb begin
    sel_val  = value[int'(pick_id)*14 +: 14];
    sel_over = (sel_val > MAX14);
  end

  // Leading-zero blanking over chars 4..1; the units digit always stays.
  always_comb begin
    blanked = cap_str;
    lead    = 1'b1;
    if (BLANK_LZ != 0) begin
      for (int i = 4; i >= 1; i--) begin
        if (lead && cap_str[i*8 +: 8] == CHAR_ZERO) blanked[i*8 +: 8] = CHAR_SPACE;
        else lead = 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);

  // Arbitration FSM with registered result and handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      rr_ptr    <= '0;
      gnt_id    <= '0;
      clamp     <= 1'b0;
      cap_str   <= STR_ZEROS;
      conv_bin  <= '0;
      out_str   <= STR_ZEROS;
      out_id    <= '0;
      out_valid <= 1'b0;
      ovf       <= 1'b0;
      ack       <= '0;
    end else begin
      out_valid <= 1'b0;
      ovf       <= 1'b0;
      ack       <= '0;
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt_id   <= pick_id;
            conv_bin <= sel_over ? MAX14 : sel_val;
            clamp    <= sel_over;
            cnt      <= LAT_M1;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            cap_str <= conv_str;
            state   <= DONE;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        DONE: begin
          out_valid <= 1'b1;
          ack       <= NREQ'(1) << gnt_id;
          out_id    <= gnt_id;
          ovf       <= clamp;
          out_str   <= blanked;
          rr_ptr    <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
